decode_stage_param: RTL and testbench

DECODE_STAGE_PARAM -- requirements
Module: decode_stage_param

---
 rtl/decode_pkg.sv | 102 ++++++++++
 rtl/regfile_param.sv | 41 ++++
 rtl/decode_stage_param.sv | 145 ++++++++++++++
 tb/tb_decode_stage_param.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_pkg.sv
// Shared decode definitions: opcode encoding, ALU control codes, control bundle
// and the instruction field-position helpers used by decode_stage_param.
package decode_pkg;

    typedef enum logic [3:0] {
        OP_NOP   = 4'b0000,
        OP_LOAD  = 4'b0001,
        OP_ADD   = 4'b0010,
        OP_SUB   = 4'b0011,
        OP_AND   = 4'b0100,
        OP_OR    = 4'b0101,
        OP_BEQ   = 4'b0110,
        OP_STORE = 4'b0111,
        OP_ADDI  = 4'b1000,
        OP_SLT   = 4'b1001
    } opcode_e;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam int OPC_W = 4;

    typedef struct packed {
        logic       reg_write;
        logic       alu_src;
        logic       mem_write;
        logic       result_src;
        logic       branch;
        logic [2:0] alu_ctrl;
    } ctrl_t;

    // Layout from the MSB down: opcode, rd, rs1, rs2, then the immediate.
    function automatic int rd_lsb(input int instr_w, input int ra_w);
        return instr_w - OPC_W - ra_w;
    endfunction

    function automatic int rs1_lsb(input int instr_w, input int ra_w);
        return instr_w - OPC_W - 2 * ra_w;
    endfunction

    function automatic int rs2_lsb(input int instr_w, input int ra_w);
        return instr_w - OPC_W - 3 * ra_w;
    endfunction

    function automatic int imm_w(input int instr_w, input int ra_w);
        return instr_w - OPC_W - 3 * ra_w;
    endfunction

    // Unlisted opcodes fall through to the all-zero NOP bundle.
    function automatic ctrl_t decode_op(input logic [3:0] op);
        ctrl_t c;
        c = '0;
        case (op)
            OP_LOAD: begin
                c.reg_write  = 1'b1;
                c.alu_src    = 1'b1;
                c.result_src = 1'b1;
                c.alu_ctrl   = ALU_ADD;
            end
            OP_ADD: begin
                c.reg_write = 1'b1;
                c.alu_ctrl  = ALU_ADD;
            end
            OP_SUB: begin
                c.reg_write = 1'b1;
                c.alu_ctrl  = ALU_SUB;
            end
            OP_AND: begin
                c.reg_write = 1'b1;
                c.alu_ctrl  = ALU_AND;
            end
            OP_OR: begin
                c.reg_write = 1'b1;
                c.alu_ctrl  = ALU_OR;
            end
            OP_BEQ: begin
                c.branch   = 1'b1;
                c.alu_ctrl = ALU_SUB;
            end
            OP_STORE: begin
                c.mem_write = 1'b1;
                c.alu_src   = 1'b1;
                c.alu_ctrl  = ALU_ADD;
            end
            OP_ADDI: begin
                c.reg_write = 1'b1;
                c.alu_src   = 1'b1;
                c.alu_ctrl  = ALU_ADD;
            end
            OP_SLT: begin
                c.reg_write = 1'b1;
                c.alu_ctrl  = ALU_SLT;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/regfile_param.sv
// NREGS x DATA_W register file, two combinational reads, one synchronous write, R0 = 0.
// Define DECODE_WB_BYPASS_EN to make a same-cycle write visible on the read ports.
module regfile_param #(
    parameter int DATA_W = 24,
    parameter int NREGS  = 32,
    localparam int RA_W  = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [RA_W-1:0]   ra1_i,
    input  logic [RA_W-1:0]   ra2_i,
    input  logic              we_i,
    input  logic [RA_W-1:0]   wa_i,
    input  logic [DATA_W-1:0] wd_i,
    output logic [DATA_W-1:0] rd1_o,
    output logic [DATA_W-1:0] rd2_o
);

    logic [DATA_W-1:0] regs_q [NREGS];

    // NOTE: this array is reset entry by entry on purpose, so it maps to flops, not an SRAM macro.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i && (wa_i != '0)) begin
            regs_q[wa_i] <= wd_i;
        end
    end

    always_comb begin
        rd1_o = (ra1_i == '0) ? '0 : regs_q[ra1_i];
        rd2_o = (ra2_i == '0) ? '0 : regs_q[ra2_i];
`ifdef DECODE_WB_BYPASS_EN
        if (we_i && (wa_i != '0) && (wa_i == ra1_i)) rd1_o = wd_i;
        if (we_i && (wa_i != '0) && (wa_i == ra2_i)) rd2_o = wd_i;
`endif
    end

endmodule

// File: rtl/decode_stage_param.sv
// Decode stage: field slicing, control decode, register file read, load-use
// detection and the D->E pipeline register. Optional macro: DECODE_WB_BYPASS_EN.
module decode_stage_param
    import decode_pkg::*;
#(
    parameter int DATA_W  = 24,
    parameter int INSTR_W = 34,
    parameter int NREGS   = 32,
    localparam int RA_W   = $clog2(NREGS)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [INSTR_W-1:0] InstrD,
    input  logic               ValidD,
    input  logic [DATA_W-1:0]  PCD,
    input  logic [DATA_W-1:0]  PCPlus4D,
    input  logic               RegWriteW,
    input  logic [RA_W-1:0]    RDW,
    input  logic [DATA_W-1:0]  ResultW,
    input  logic               StallD,
    input  logic               FlushE,
    output logic               HazardStall,
    output logic               ValidE,
    output logic               RegWriteE,
    output logic               ALUSrcE,
    output logic               MemWriteE,
    output logic               ResultSrcE,
    output logic               BranchE,
    output logic [2:0]         ALUControlE,
    output logic [DATA_W-1:0]  RD1_E,
    output logic [DATA_W-1:0]  RD2_E,
    output logic [DATA_W-1:0]  Imm_Ext_E,
    output logic [DATA_W-1:0]  PCE,
    output logic [DATA_W-1:0]  PCPlus4E,
    output logic [RA_W-1:0]    RS1_E,
    output logic [RA_W-1:0]    RS2_E,
    output logic [RA_W-1:0]    RD_E
);

    localparam int IMM_W = imm_w(INSTR_W, RA_W);

    typedef struct packed {
        logic              valid;
        ctrl_t             ctrl;
        logic [DATA_W-1:0] rd1;
        logic [DATA_W-1:0] rd2;
        logic [DATA_W-1:0] imm;
        logic [DATA_W-1:0] pc;
        logic [DATA_W-1:0] pc4;
        logic [RA_W-1:0]   rs1;
        logic [RA_W-1:0]   rs2;
        logic [RA_W-1:0]   rd;
    } e_reg_t;

    logic [3:0]        opcode_d;
    logic [RA_W-1:0]   rd_d;
    logic [RA_W-1:0]   rs1_d;
    logic [RA_W-1:0]   rs2_d;
    logic [IMM_W-1:0]  imm_d;
    logic [DATA_W-1:0] imm_ext_d;
    logic [DATA_W-1:0] rd1_d;
    logic [DATA_W-1:0] rd2_d;
    e_reg_t            e_q;
    e_reg_t            e_d;

    assign opcode_d = InstrD[INSTR_W-1 -: OPC_W];
    assign rd_d     = InstrD[rd_lsb(INSTR_W, RA_W)  +: RA_W];
    assign rs1_d    = InstrD[rs1_lsb(INSTR_W, RA_W) +: RA_W];
    assign rs2_d    = InstrD[rs2_lsb(INSTR_W, RA_W) +: RA_W];
    assign imm_d    = InstrD[IMM_W-1:0];

    if (IMM_W >= DATA_W) begin : g_imm_trunc
        assign imm_ext_d = imm_d[DATA_W-1:0];
    end else begin : g_imm_sext
        assign imm_ext_d = {{(DATA_W - IMM_W){imm_d[IMM_W-1]}}, imm_d};
    end

    regfile_param #(
        .DATA_W (DATA_W),
        .NREGS  (NREGS)
    ) u_regfile (
        .clk   (clk),
        .rst   (rst),
        .ra1_i (rs1_d),
        .ra2_i (rs2_d),
        .we_i  (RegWriteW),
        .wa_i  (RDW),
        .wd_i  (ResultW),
        .rd1_o (rd1_d),
        .rd2_o (rd2_d)
    );

    // A load in E whose destination is a source of the instruction in D.
    assign HazardStall = e_q.valid && e_q.ctrl.result_src && (e_q.rd != '0) && ValidD
                         && ((e_q.rd == rs1_d) || (e_q.rd == rs2_d));

    // NOTE: e_d starts as a copy of e_q so every path assigns it and no latch is inferred.
    always_comb begin
        e_d = e_q;
        if (FlushE || HazardStall) begin
            e_d = '0;
        end else if (StallD) begin
            e_d = e_q;
        end else if (!ValidD) begin
            e_d = '0;
        end else begin
            e_d.valid = 1'b1;
            e_d.ctrl  = decode_op(opcode_d);
            e_d.rd1   = rd1_d;
            e_d.rd2   = rd2_d;
            e_d.imm   = imm_ext_d;
            e_d.pc    = PCD;
            e_d.pc4   = PCPlus4D;
            e_d.rs1   = rs1_d;
            e_d.rs2   = rs2_d;
            e_d.rd    = rd_d;
        end
    end

    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            e_q <= '0;
        end else begin
            e_q <= e_d;
        end
    end

    assign ValidE      = e_q.valid;
    assign RegWriteE   = e_q.ctrl.reg_write;
    assign ALUSrcE     = e_q.ctrl.alu_src;
    assign MemWriteE   = e_q.ctrl.mem_write;
    assign ResultSrcE  = e_q.ctrl.result_src;
    assign BranchE     = e_q.ctrl.branch;
    assign ALUControlE = e_q.ctrl.alu_ctrl;
    assign RD1_E       = e_q.rd1;
    assign RD2_E       = e_q.rd2;
    assign Imm_Ext_E   = e_q.imm;
    assign PCE         = e_q.pc;
    assign PCPlus4E    = e_q.pc4;
    assign RS1_E       = e_q.rs1;
    assign RS2_E       = e_q.rs2;
    assign RD_E        = e_q.rd;

endmodule

// File: tb/tb_decode_stage_param.sv
// Scoreboard bench for decode_stage_param: a behavioural model predicts the E
// register and HazardStall each cycle; a monitor compares them against the DUT.
module tb_decode_stage_param;

    logic        clk = 1'b0;
    logic        rst;
    logic [33:0] InstrD;
    logic        ValidD;
    logic [23:0] PCD, PCPlus4D, ResultW;
    logic        RegWriteW, StallD, FlushE;
    logic [4:0]  RDW;
    logic        HazardStall, ValidE, RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE;
    logic [2:0]  ALUControlE;
    logic [23:0] RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E;
    logic [4:0]  RS1_E, RS2_E, RD_E;

    // Second instance for the wide-parameter sweep (IMM_W = 24).
    logic [39:0] instr2;
    logic        hz2, valid2, rw2, alusrc2, mw2, rsrc2, br2;
    logic [2:0]  alu2;
    logic [31:0] rd1_2, rd2_2, imm2, pc2, pc4_2;
    logic [3:0]  rs1_2, rs2_2, rd_2;

    always #5 clk = ~clk;

    decode_stage_param dut (
        .clk(clk), .rst(rst), .InstrD(InstrD), .ValidD(ValidD), .PCD(PCD), .PCPlus4D(PCPlus4D),
        .RegWriteW(RegWriteW), .RDW(RDW), .ResultW(ResultW), .StallD(StallD), .FlushE(FlushE),
        .HazardStall(HazardStall), .ValidE(ValidE), .RegWriteE(RegWriteE), .ALUSrcE(ALUSrcE),
        .MemWriteE(MemWriteE), .ResultSrcE(ResultSrcE), .BranchE(BranchE), .ALUControlE(ALUControlE),
        .RD1_E(RD1_E), .RD2_E(RD2_E), .Imm_Ext_E(Imm_Ext_E), .PCE(PCE), .PCPlus4E(PCPlus4E),
        .RS1_E(RS1_E), .RS2_E(RS2_E), .RD_E(RD_E)
    );

    decode_stage_param #(.DATA_W(32), .INSTR_W(40), .NREGS(16)) dut2 (
        .clk(clk), .rst(rst), .InstrD(instr2), .ValidD(1'b1), .PCD(32'h0), .PCPlus4D(32'h4),
        .RegWriteW(1'b0), .RDW(4'h0), .ResultW(32'h0), .StallD(1'b0), .FlushE(1'b0),
        .HazardStall(hz2), .ValidE(valid2), .RegWriteE(rw2), .ALUSrcE(alusrc2),
        .MemWriteE(mw2), .ResultSrcE(rsrc2), .BranchE(br2), .ALUControlE(alu2),
        .RD1_E(rd1_2), .RD2_E(rd2_2), .Imm_Ext_E(imm2), .PCE(pc2), .PCPlus4E(pc4_2),
        .RS1_E(rs1_2), .RS2_E(rs2_2), .RD_E(rd_2)
    );

    typedef struct packed {
        logic        valid, rw, alusrc, mw, rsrc, br;
        logic [2:0]  alu;
        logic [23:0] rd1, rd2, imm, pc, pc4;
        logic [4:0]  rs1, rs2, rd;
    } e_t;

    typedef struct { int cyc; e_t e; } e_item_t;
    typedef struct { int cyc; logic hz; } hz_item_t;

    e_item_t  e_q[$];
    hz_item_t hz_q[$];
    int       cyc = 0;
    int       n_pass = 0;
    int       n_total = 0;

    // Reference state: architectural registers and the expected E contents.
    logic [23:0] m_regs [32];
    e_t          m_e;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else n_pass++;
    endtask

    function automatic logic [33:0] mk(input int op, input int rd, input int rs1, input int rs2,
                                       input logic [14:0] imm);
        logic [3:0] o;
        logic [4:0] a, b, c;
        o = 4'(op); a = 5'(rd); b = 5'(rs1); c = 5'(rs2);
        return {o, a, b, c, imm};
    endfunction

    // Control table straight from the opcode list.
    function automatic e_t ctrl_of(input int op);
        e_t c;
        c = '0;
        case (op)
            1: begin c.rw = 1; c.alusrc = 1; c.rsrc = 1; c.alu = 3'd0; end
            2: begin c.rw = 1; c.alu = 3'd0; end
            3: begin c.rw = 1; c.alu = 3'd1; end
            4: begin c.rw = 1; c.alu = 3'd2; end
            5: begin c.rw = 1; c.alu = 3'd3; end
            6: begin c.br = 1; c.alu = 3'd1; end
            7: begin c.mw = 1; c.alusrc = 1; c.alu = 3'd0; end
            8: begin c.rw = 1; c.alusrc = 1; c.alu = 3'd0; end
            9: begin c.rw = 1; c.alu = 3'd5; end
            default: c = '0;
        endcase
        return c;
    endfunction

    function automatic logic [23:0] rf_read(input int a, input logic w, input int wa, input logic [23:0] wd);
        if (a == 0) return 24'h0;
`ifdef DECODE_WB_BYPASS_EN
        if (w && wa == a) return wd;
`endif
        return m_regs[a];
    endfunction

    // Drive one cycle of inputs and queue the model's predictions for it.
    task automatic drive(input logic r, input logic [33:0] ins, input logic v, input logic [23:0] pc,
                         input logic w, input logic [4:0] wa, input logic [23:0] wd,
                         input logic st, input logic fl);
        int op, rd, rs1, rs2, immv;
        logic hz;
        e_t ld, nxt;
        rst = r; InstrD = ins; ValidD = v; PCD = pc; PCPlus4D = pc + 24'd4;
        RegWriteW = w; RDW = wa; ResultW = wd; StallD = st; FlushE = fl;
        op = int'(ins[33:30]); rd = int'(ins[29:25]); rs1 = int'(ins[24:20]); rs2 = int'(ins[19:15]);
        immv = int'(ins[14:0]);
        if (immv >= 16384) immv -= 32768;
        hz = m_e.valid && m_e.rsrc && (m_e.rd != 0) && v && (int'(m_e.rd) == rs1 || int'(m_e.rd) == rs2);
        hz_q.push_back('{cyc, hz});
        ld = ctrl_of(op);
        ld.valid = 1'b1;
        ld.rd1 = rf_read(rs1, w, int'(wa), wd);
        ld.rd2 = rf_read(rs2, w, int'(wa), wd);
        ld.imm = 24'(immv);
        ld.pc = pc; ld.pc4 = pc + 24'd4;
        ld.rs1 = 5'(rs1); ld.rs2 = 5'(rs2); ld.rd = 5'(rd);
        if (r) nxt = '0;
        else if (fl || hz) nxt = '0;
        else if (st) nxt = m_e;
        else if (!v) nxt = '0;
        else nxt = ld;
        e_q.push_back('{cyc + 1, nxt});
        m_e = nxt;
        if (r) begin
            for (int i = 0; i < 32; i++) m_regs[i] = 24'h0;
        end else if (w && wa != 0) begin
            m_regs[wa] = wd;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input logic r, input logic [33:0] ins, input logic v, input logic [23:0] pc,
                        input logic w, input logic [4:0] wa, input logic [23:0] wd,
                        input logic st, input logic fl);
        drive(r, ins, v, pc, w, wa, wd, st, fl);
        tick();
    endtask

    // Monitor: compare predictions whose cycle has come, away from the rising edge.
    initial begin
        e_t act;
        forever begin
            @(negedge clk);
            while (hz_q.size() > 0 && hz_q[0].cyc <= cyc) begin
                hz_item_t h;
                h = hz_q.pop_front();
                check("hazard_stall", 64'(HazardStall), 64'(h.hz));
            end
            while (e_q.size() > 0 && e_q[0].cyc <= cyc) begin
                e_item_t it;
                it = e_q.pop_front();
                act = '{ValidE, RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE, ALUControlE,
                        RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E, RS1_E, RS2_E, RD_E};
                n_total++;
                if (act !== it.e) $display("FAIL e_reg cyc %0d: got %h expected %h", it.cyc, act, it.e);
                else n_pass++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1);
    end

    initial begin
        logic [23:0] exp_byp;
        for (int i = 0; i < 32; i++) m_regs[i] = 24'h0;
        m_e = '0;
        instr2 = {4'b1000, 4'd1, 4'd0, 4'd0, 24'h800000};
        rst = 1; InstrD = '0; ValidD = 0; PCD = '0; PCPlus4D = '0;
        RegWriteW = 0; RDW = '0; ResultW = '0; StallD = 0; FlushE = 0;
        tick();

        // Reset with a concurrent write that must be discarded.
        step(1, mk(0, 0, 0, 0, 0), 0, 0, 1, 5'd5, 24'h777, 0, 0);
        check("reset_valid", 64'(ValidE), 0);
        check("reset_pce", 64'(PCE), 0);

        // ADDI rd=2, rs1=1, imm=-3 after writing R1=5.
        step(0, mk(0, 0, 0, 0, 0), 0, 0, 1, 5'd1, 24'h000005, 0, 0);
        step(0, mk(8, 2, 1, 0, 15'h7FFD), 1, 24'h10, 0, 0, 0, 0, 0);
        check("addi_regwrite", 64'(RegWriteE), 1);
        check("addi_alusrc", 64'(ALUSrcE), 1);
        check("addi_rd1", 64'(RD1_E), 64'h000005);
        check("addi_imm", 64'(Imm_Ext_E), 64'hFFFFFD);
        check("addi_rd", 64'(RD_E), 2);
        check("addi_valid", 64'(ValidE), 1);
        check("sweep_imm", 64'(imm2), 64'hFF800000);
        check("sweep_valid", 64'(valid2), 1);

        // Load-use: LOAD rd=3 in E, ADD rs1=3 in D.
        step(0, mk(1, 3, 1, 0, 15'd4), 1, 24'h20, 0, 0, 0, 0, 0);
        drive(0, mk(2, 4, 3, 0, 0), 1, 24'h24, 0, 0, 0, 0, 0);
        #1;
        check("loaduse_hazard", 64'(HazardStall), 1);
        tick();
        check("loaduse_bubble", 64'(ValidE), 0);
        step(0, mk(2, 4, 3, 0, 0), 1, 24'h24, 0, 0, 0, 0, 0);
        check("loaduse_accept", 64'(ValidE), 1);
        check("loaduse_rs1", 64'(RS1_E), 3);

        // Stall holds E for three cycles, then stall+flush yields a bubble.
        step(0, mk(2, 5, 1, 2, 0), 1, 24'h14, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, mk(3, 6, 2, 1, 0), 1, 24'h18, 0, 0, 0, 1, 0);
            check("stall_pce", 64'(PCE), 64'h14);
            check("stall_rd", 64'(RD_E), 5);
        end
        step(0, mk(3, 6, 2, 1, 0), 1, 24'h18, 0, 0, 0, 1, 1);
        check("flush_valid", 64'(ValidE), 0);
        check("flush_pce", 64'(PCE), 0);

        // Writeback to R4 while reading it; then a write to R0.
`ifdef DECODE_WB_BYPASS_EN
        exp_byp = 24'h00ABCD;
`else
        exp_byp = 24'h000000;
`endif
        step(0, mk(2, 6, 4, 0, 0), 1, 24'h30, 1, 5'd4, 24'h00ABCD, 0, 0);
        check("bypass_rd1", 64'(RD1_E), 64'(exp_byp));
        step(0, mk(2, 6, 0, 4, 0), 1, 24'h34, 1, 5'd0, 24'h000123, 0, 0);
        check("r0_write_rd1", 64'(RD1_E), 0);
        check("r4_next_cycle", 64'(RD2_E), 64'h00ABCD);
        step(0, mk(2, 6, 0, 0, 0), 1, 24'h38, 0, 0, 0, 0, 0);
        check("r0_read", 64'(RD1_E), 0);

        // Reset while E holds BEQ.
        step(0, mk(6, 0, 1, 4, 15'd8), 1, 24'h40, 0, 0, 0, 0, 0);
        check("beq_branch", 64'(BranchE), 1);
        step(1, mk(6, 0, 1, 4, 15'd8), 1, 24'h44, 0, 0, 0, 0, 0);
        check("rst_mid_valid", 64'(ValidE), 0);
        check("rst_mid_branch", 64'(BranchE), 0);
        check("rst_mid_alu", 64'(ALUControlE), 0);
        check("rst_mid_pc", 64'(PCE), 0);
        step(0, mk(2, 7, 1, 4, 0), 1, 24'h48, 0, 0, 0, 0, 0);
        check("rst_rf_rd1", 64'(RD1_E), 0);
        check("rst_rf_rd2", 64'(RD2_E), 0);

        // Randomised traffic with narrow register range to provoke hazards.
        for (int i = 0; i < 500; i++) begin
            logic [33:0] ins;
            ins = mk(int'($urandom_range(0, 15)), int'($urandom_range(0, 7)),
                     int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), 15'($urandom));
            step($urandom_range(0, 99) < 2, ins, $urandom_range(0, 99) < 85, 24'($urandom),
                 $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), 24'($urandom),
                 $urandom_range(0, 99) < 20, $urandom_range(0, 99) < 8);
        end

        step(0, mk(0, 0, 0, 0, 0), 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        #1;
        check("scoreboard_drained", 64'(e_q.size() + hz_q.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
